run_timer_monitor: RTL

Downstream consumer of a core's completion flag (`o_core_locked`) in the single-core test build. It measures the clock cycles from core start to completion and enforces an optional timeout. It latches the final count for readout and drives a registered status LED: off, heartbeat blink, solid, or fast blink. The LED signal feeds the board's done-LED output buffer.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/blink_prescaler.sv | 31 +++
 rtl/run_timer_monitor.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the single-core test build.
// mon_state_t fixes the run_timer_monitor debug encoding (o_state) so that
// debug tooling decodes it the same way as the RTL.
package riscv_pkg;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_RUN     = 2'd1,
        MON_DONE    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running wrapping up-counter used to derive LED blink rates.
// Ports:
//   clk      - counter clock
//   reset    - asynchronous active-high clear
//   slow_tap - counter bit SLOW_BIT (period 2^(SLOW_BIT+1) cycles)
//   fast_tap - counter bit FAST_BIT (period 2^(FAST_BIT+1) cycles)
module blink_prescaler #(
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned SLOW_BIT = 25,
    parameter int unsigned FAST_BIT = 21
) (
    input  logic clk,
    input  logic reset,
    output logic slow_tap,
    output logic fast_tap
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign slow_tap = count[SLOW_BIT];
    assign fast_tap = count[FAST_BIT];

endmodule

// File: rtl/run_timer_monitor.sv
// Measures core run time from start to completion, with optional timeout.
// Ports:
//   clk           - core clock
//   reset         - asynchronous active-high reset
//   i_start       - level, high once the core is out of reset
//   i_done        - level, core completion flag (same clock domain)
//   o_led         - registered status LED (off / heartbeat / solid / fast blink)
//   o_cycle_count - running count, frozen in DONE, TIMEOUT_CYCLES in TIMEOUT
//   o_count_valid - high in DONE
//   o_timeout     - high in TIMEOUT
//   o_state       - debug state encoding (mon_state_t)
module run_timer_monitor
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 48,
    parameter int unsigned TIMEOUT_CYCLES  = 0,
    parameter int unsigned HEARTBEAT_LOG2  = 26,
    parameter int unsigned FAST_BLINK_LOG2 = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_done,
    output logic                 o_led,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic                 o_count_valid,
    output logic                 o_timeout,
    output logic [1:0]           o_state
);

    localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_VAL - CNT_WIDTH'(1);

    mon_state_t           state, state_d;
    logic [CNT_WIDTH-1:0] count, count_d;
    logic                 led_d;
    logic                 slow_tap, fast_tap;

    blink_prescaler #(
        .WIDTH    (HEARTBEAT_LOG2),
        .SLOW_BIT (HEARTBEAT_LOG2 - 1),
        .FAST_BIT (FAST_BLINK_LOG2 - 1)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .slow_tap (slow_tap),
        .fast_tap (fast_tap)
    );

    always_comb begin
        state_d = state;
        count_d = count;
        unique case (state)
            MON_IDLE: begin
                if (i_start) begin
                    state_d = MON_RUN;
                end
            end
            MON_RUN: begin
                // Done has priority over timeout; count freezes without
                // counting the cycle in which done was seen.
                if (i_done) begin
                    state_d = MON_DONE;
                end else if (TIMEOUT_EN && (count == TIMEOUT_LAST)) begin
                    state_d = MON_TIMEOUT;
                    count_d = TIMEOUT_VAL;
                end else if (count != '1) begin
                    count_d = count + CNT_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        led_d = 1'b0;
        unique case (state)
            MON_IDLE:    led_d = 1'b0;
            MON_RUN:     led_d = slow_tap;
            MON_DONE:    led_d = 1'b1;
            MON_TIMEOUT: led_d = fast_tap;
            default:     led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MON_IDLE;
            count <= '0;
            o_led <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            o_led <= led_d;
        end
    end

    assign o_state       = state;
    assign o_cycle_count = count;
    assign o_count_valid = (state == MON_DONE);
    assign o_timeout     = (state == MON_TIMEOUT);

endmodule
